// File: rtl/ws2811_pkg.sv
// Shared definitions for the WS2811 strip scheduler: FSM encoding and default timing constants.
package ws2811_pkg;

  localparam int STATE_W            = 3;
  localparam int DEF_GAP_CYCLES     = 50;
  localparam int DEF_TIMEOUT_CYCLES = 2000000;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'b000,
    ST_ARB    = 3'b001,
    ST_GAP    = 3'b010,
    ST_RUN    = 3'b011,
    ST_FINISH = 3'b100
  } state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2811_rr_picker.sv
// Combinational round-robin find-first: lowest pending index at or after rr_ptr, wrapping.
module ws2811_rr_picker
  import ws2811_pkg::*;
#(
  parameter int N_STRIPS = 4,
  parameter int IDX_W    = idx_width(N_STRIPS)
) (
  input  logic [N_STRIPS-1:0] pending_i,
  input  logic [IDX_W-1:0]    rr_ptr_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  localparam int             CW  = IDX_W + 1;
  localparam logic [CW-1:0]  N_C = CW'(N_STRIPS);

  logic [CW-1:0] cand;

  // Walk offsets from the farthest to the nearest so the nearest hit is the one that sticks.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = N_STRIPS - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr_i} + CW'(off);
      if (cand >= N_C) begin
        cand = cand - N_C;
      end
      if (pending_i[cand[IDX_W-1:0]]) begin
        idx_o   = cand[IDX_W-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws2811_strip_scheduler.sv
// Time-shares one WS2811 array controller across N_STRIPS strips: latches requests, grants
// round-robin, routes the data pin, enables the controller and supervises each frame.
module ws2811_strip_scheduler
  import ws2811_pkg::*;
#(
  parameter int N_STRIPS       = 4,
  parameter int LEDS_PER_STRIP = 64,
  parameter int ADDR_W         = 9,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_STRIPS-1:0] refresh_req_i,
  input  logic                ctrl_frame_done_i,
  input  logic                clear_err_i,
  output logic                ctrl_enable_o,
  output logic [ADDR_W-1:0]   ctrl_base_addr_o,
  output logic [N_STRIPS-1:0] strip_sel_o,
  output logic [N_STRIPS-1:0] strip_done_o,
  output logic                timeout_err_o,
  output logic                busy_o,
  output logic [N_STRIPS-1:0] pending_o,
  output logic [STATE_W-1:0]  db_estado_o
);

  localparam int IDX_W = idx_width(N_STRIPS);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_STRIPS - 1);

  if (N_STRIPS < 2 || N_STRIPS > 8) begin : g_bad_n_strips
    $error("ws2811_strip_scheduler: N_STRIPS must be within 2..8");
  end
  if (N_STRIPS * LEDS_PER_STRIP > 2 ** ADDR_W) begin : g_bad_addr_w
    $error("ws2811_strip_scheduler: ADDR_W too narrow for N_STRIPS*LEDS_PER_STRIP");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("ws2811_strip_scheduler: GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("ws2811_strip_scheduler: TIMEOUT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Control unit
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  logic [N_STRIPS-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [N_STRIPS-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                ok_q, ok_d;
  logic                timeout_err_q, timeout_err_d;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                arb_load;
  logic                run_ok;
  logic                run_to;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A frame-done pulse in the same cycle as watchdog expiry is treated as success.
  always_comb begin
    state_d  = state_q;
    arb_load = 1'b0;
    run_ok   = 1'b0;
    run_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_valid) begin
          arb_load = 1'b1;
          state_d  = ST_GAP;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ctrl_frame_done_i) begin
          run_ok  = 1'b1;
          state_d = ST_FINISH;
        end else if (wd_q == WD_LAST) begin
          run_to  = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = (|pending_q) ? ST_ARB : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  ws2811_rr_picker #(
    .N_STRIPS (N_STRIPS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  // A request arriving in the granting cycle survives the clear and is served again later.
  always_comb begin
    pending_d     = (pending_q & ~(arb_load ? (N_STRIPS'(1) << pick_idx) : '0)) | refresh_req_i;
    grant_d       = arb_load ? pick_idx : grant_q;
    base_d        = arb_load ? ADDR_W'(int'(pick_idx) * LEDS_PER_STRIP) : base_q;
    sel_d         = sel_q;
    gap_d         = gap_q;
    wd_d          = wd_q;
    ok_d          = ok_q;
    rr_ptr_d      = rr_ptr_q;
    timeout_err_d = run_to ? 1'b1 : (clear_err_i ? 1'b0 : timeout_err_q);

    if (arb_load) begin
      sel_d = N_STRIPS'(1) << pick_idx;
      gap_d = '0;
    end else if (state_q == ST_GAP) begin
      gap_d = gap_q + GAP_W'(1);
    end

    if (state_q == ST_GAP) begin
      wd_d = '0;
    end else if (state_q == ST_RUN) begin
      wd_d = wd_q + WD_W'(1);
    end

    // Drop the data route as the frame ends so FINISH already sees a disconnected pin.
    if (run_ok || run_to) begin
      sel_d = '0;
      ok_d  = run_ok;
    end

    if (state_q == ST_FINISH) begin
      rr_ptr_d = (grant_q == IDX_LAST) ? '0 : grant_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      sel_q         <= '0;
      base_q        <= '0;
      gap_q         <= '0;
      wd_q          <= '0;
      ok_q          <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      sel_q         <= sel_d;
      base_q        <= base_d;
      gap_q         <= gap_d;
      wd_q          <= wd_d;
      ok_q          <= ok_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ctrl_enable_o    = (state_q == ST_RUN);
  assign ctrl_base_addr_o = base_q;
  assign strip_sel_o      = sel_q;
  assign strip_done_o     = ((state_q == ST_FINISH) && ok_q) ? (N_STRIPS'(1) << grant_q) : '0;
  assign timeout_err_o    = timeout_err_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign pending_o        = pending_q;
  assign db_estado_o      = state_q;

endmodule

// File: tb/tb_ws2811_strip_scheduler.sv
// Directed bench for ws2811_strip_scheduler with a frame-level reference model checked every cycle.
module tb_ws2811_strip_scheduler;

  localparam int N    = 4;
  localparam int LEDS = 64;
  localparam int AW   = 9;
  localparam int GAP  = 4;
  localparam int TMO  = 100;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          fd;
  logic          ce;
  logic          ctrl_enable;
  logic [AW-1:0] base_addr;
  logic [N-1:0]  strip_sel;
  logic [N-1:0]  strip_done;
  logic          timeout_err;
  logic          busy;
  logic [N-1:0]  pending;
  logic [2:0]    db_estado;

  ws2811_strip_scheduler #(
    .N_STRIPS       (N),
    .LEDS_PER_STRIP (LEDS),
    .ADDR_W         (AW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .refresh_req_i     (req),
    .ctrl_frame_done_i (fd),
    .clear_err_i       (ce),
    .ctrl_enable_o     (ctrl_enable),
    .ctrl_base_addr_o  (base_addr),
    .strip_sel_o       (strip_sel),
    .strip_done_o      (strip_done),
    .timeout_err_o     (timeout_err),
    .busy_o            (busy),
    .pending_o         (pending),
    .db_estado_o       (db_estado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation ran past 500000 time units, required to finish earlier");
    $fatal(1);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode 0 = idle, 1 = serving a frame (age counts cycles since arbitration began), 2 = wrap-up cycle.
  int          m_mode  = 0;
  int          m_age   = 0;
  int          m_grant = 0;
  int          m_rr    = 0;
  int          m_base  = 0;
  bit          m_ok    = 1'b0;
  logic [N-1:0] m_pend = '0;
  logic        m_terr  = 1'b0;
  logic [N-1:0] m_clr;
  bit          m_tset;
  bit          m_found;
  int          m_j;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_grant = 0; m_rr = 0; m_base = 0;
      m_ok = 1'b0; m_pend = '0; m_terr = 1'b0;
    end else begin
      m_clr  = '0;
      m_tset = 1'b0;
      case (m_mode)
        0: if (m_pend != 0) begin m_mode = 1; m_age = 0; end
        1: begin
          if (m_age == 0) begin
            m_found = 1'b0;
            for (int o = 0; o < N; o++) begin
              m_j = (m_rr + o) % N;
              if (!m_found && m_pend[m_j[1:0]]) begin
                m_found = 1'b1;
                m_grant = m_j;
              end
            end
            if (m_found) begin
              m_clr[m_grant[1:0]] = 1'b1;
              m_base = m_grant * LEDS;
              m_age  = 1;
            end else begin
              m_mode = 0;
            end
          end else if (m_age <= GAP) begin
            m_age++;
          end else if (fd) begin
            m_mode = 2; m_ok = 1'b1;
          end else if (m_age - GAP - 1 == TMO - 1) begin
            m_mode = 2; m_ok = 1'b0; m_tset = 1'b1;
          end else begin
            m_age++;
          end
        end
        default: begin
          m_rr = (m_grant + 1) % N;
          if (m_pend != 0) begin m_mode = 1; m_age = 0; end
          else m_mode = 0;
        end
      endcase
      m_pend = (m_pend & ~m_clr) | req;
      m_terr = m_tset ? 1'b1 : (ce ? 1'b0 : m_terr);
    end
  end

  // ---------------- compare process ----------------
  int           e_state;
  logic         e_en;
  logic [N-1:0] e_sel;
  logic [N-1:0] e_done;
  logic [N-1:0] e_pop;

  always @(negedge clk) begin
    e_state = (m_mode == 0) ? 0 : (m_mode == 2) ? 4 : (m_age == 0) ? 1 : (m_age <= GAP) ? 2 : 3;
    e_en    = (m_mode == 1) && (m_age > GAP);
    e_sel   = ((m_mode == 1) && (m_age >= 1)) ? (4'b0001 << m_grant) : 4'b0000;
    e_done  = ((m_mode == 2) && m_ok) ? (4'b0001 << m_grant) : 4'b0000;
    chk("m_state",   32'(db_estado),   32'(e_state));
    chk("m_enable",  32'(ctrl_enable), 32'(e_en));
    chk("m_sel",     32'(strip_sel),   32'(e_sel));
    chk("m_base",    32'(base_addr),   32'(m_base));
    chk("m_done",    32'(strip_done),  32'(e_done));
    chk("m_terr",    32'(timeout_err), 32'(m_terr));
    chk("m_busy",    32'(busy),        32'(m_mode != 0));
    chk("m_pending", 32'(pending),     32'(m_pend));
    if (strip_done != 0) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(strip_done), 32'd0);
      end else begin
        e_pop = exp_q.pop_front();
        chk("done_order", 32'(strip_done), 32'(e_pop));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Every task leaves the bench 2 time units after a rising edge, where inputs may change safely.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic pulse_req(input logic [N-1:0] r);
    req = r;
    cyc();
    req = '0;
  endtask

  task automatic wait_run(input int max_cycles);
    int n = 0;
    while (!ctrl_enable && n < max_cycles) begin
      cyc();
      n++;
    end
    chk("wait_run", 32'(ctrl_enable), 32'd1);
  endtask

  task automatic finish_frame(input logic [N-1:0] sel_exp);
    wait_run(40);
    chk("run_sel", 32'(strip_sel), 32'(sel_exp));
    exp_q.push_back(sel_exp);
    fd = 1'b1;
    cyc();
    fd = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    req   = '0;
    fd    = 1'b0;
    ce    = 1'b0;
    cyc();
    cyc();
    chk("rst_state", 32'(db_estado), 32'd0);
    chk("rst_sel",   32'(strip_sel), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: single request, exact latency to enable, done pulse, back to idle
    pulse_req(4'b0100);
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_idle",    32'(db_estado), 32'd0);
    cyc();
    chk("t1_arb",     32'(db_estado), 32'd1);
    cyc();
    chk("t1_sel",     32'(strip_sel), 32'h4);
    chk("t1_base",    32'(base_addr), 32'd128);
    repeat (3) cyc();
    chk("t1_en_low",  32'(ctrl_enable), 32'd0);
    cyc();
    chk("t1_en_high", 32'(ctrl_enable), 32'd1);
    exp_q.push_back(4'b0100);
    fd = 1'b1;
    cyc();
    fd = 1'b0;
    chk("t1_done",    32'(strip_done), 32'h4);
    chk("t1_fin_sel", 32'(strip_sel),  32'd0);
    cyc();
    chk("t1_back_idle", 32'(busy), 32'd0);

    // 2: all four at once from rr_ptr=0, then 1001 from rr_ptr=1
    do_reset();
    pulse_req(4'b1111);
    finish_frame(4'b0001);
    finish_frame(4'b0010);
    finish_frame(4'b0100);
    finish_frame(4'b1000);
    cyc();
    pulse_req(4'b0001);
    finish_frame(4'b0001);
    cyc();
    pulse_req(4'b1001);
    finish_frame(4'b1000);
    finish_frame(4'b0001);
    cyc();

    // 3: timeout on strip 1 with clear_err colliding with expiry, then strip 2 served
    pulse_req(4'b0110);
    wait_run(40);
    chk("t3_sel", 32'(strip_sel), 32'h2);
    repeat (TMO - 1) cyc();
    chk("t3_last_run_en", 32'(ctrl_enable), 32'd1);
    chk("t3_pre_err",     32'(timeout_err), 32'd0);
    ce = 1'b1;
    cyc();
    ce = 1'b0;
    chk("t3_err_set",  32'(timeout_err), 32'd1);
    chk("t3_no_done",  32'(strip_done),  32'd0);
    chk("t3_finish",   32'(db_estado),   32'd4);
    finish_frame(4'b0100);
    cyc();
    ce = 1'b1;
    cyc();
    ce = 1'b0;
    chk("t3_err_clr", 32'(timeout_err), 32'd0);

    // 4: request re-asserted in the cycle that grants it
    pulse_req(4'b0010);
    cyc();
    chk("t4_arb", 32'(db_estado), 32'd1);
    pulse_req(4'b0010);
    chk("t4_pending_kept", 32'(pending),   32'h2);
    chk("t4_sel",          32'(strip_sel), 32'h2);
    finish_frame(4'b0010);
    finish_frame(4'b0010);
    cyc();

    // 5: asynchronous reset in the middle of a frame, then a stray frame_done in idle
    pulse_req(4'b0001);
    wait_run(40);
    pulse_req(4'b1000);
    rst_n = 1'b0;
    #1;
    chk("t5_sel",     32'(strip_sel),   32'd0);
    chk("t5_en",      32'(ctrl_enable), 32'd0);
    chk("t5_pending", 32'(pending),     32'd0);
    chk("t5_state",   32'(db_estado),   32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    fd = 1'b1;
    cyc();
    fd = 1'b0;
    chk("t5_fd_idle_state", 32'(db_estado),  32'd0);
    chk("t5_fd_idle_done",  32'(strip_done), 32'd0);
    cyc();

    // 6: frame_done in the very cycle the watchdog would expire
    pulse_req(4'b0001);
    wait_run(40);
    repeat (TMO - 1) cyc();
    exp_q.push_back(4'b0001);
    fd = 1'b1;
    cyc();
    fd = 1'b0;
    chk("t6_done", 32'(strip_done),  32'h1);
    chk("t6_terr", 32'(timeout_err), 32'd0);
    repeat (3) cyc();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
